// File: rtl/ppi_ex_pkg.sv
// Shared constants and helpers for the ppi_ex slot/PPI block.
package ppi_ex_pkg;

  localparam logic [1:0] PORT_A    = 2'd0;
  localparam logic [1:0] PORT_B    = 2'd1;
  localparam logic [1:0] PORT_C    = 2'd2;
  localparam logic [1:0] PORT_CTRL = 2'd3;

  localparam logic [15:0] SUBSLOT_ADDR = 16'hFFFF;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_IO,
    ACC_MEM
  } acc_kind_t;

  function automatic logic [3:0] onehot4(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/ppi_ex_if.sv
// Z80-style bus as seen by the PPI: strobes, address, write data and read return.
interface ppi_ex_if;
  logic        iorq_n;
  logic        mreq_n;
  logic        wr_n;
  logic        rd_n;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_en;

  modport master (
    output iorq_n, mreq_n, wr_n, rd_n, address, wdata,
    input  rdata, rdata_en
  );

  modport slave (
    input  iorq_n, mreq_n, wr_n, rd_n, address, wdata,
    output rdata, rdata_en
  );
endinterface

// File: rtl/ppi_ex_subslot.sv
// Secondary slot register of one expanded primary slot and its per-page decode.
module ppi_ex_subslot
  import ppi_ex_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [7:0] wdata,
  input  logic [1:0] page,
  input  logic       mute,
  output logic [7:0] sub_reg,
  output logic [3:0] sel
);

  always_ff @(posedge clk) begin
    if (reset)
      sub_reg <= 8'h00;
    else if (we)
      sub_reg <= wdata;
  end

  // Muted while the register itself is being read so no cartridge drives the bus.
  always_comb begin
    sel = mute ? 4'b0000 : onehot4(sub_reg[{page, 1'b0} +: 2]);
  end

endmodule

// File: rtl/ppi_ex.sv
// 8255-style PPI with primary slot select and FFFFh secondary slot registers.
// Optional macro PPI_PORTC_BSR_EN enables port C bit set/reset via the control port.
module ppi_ex
  import ppi_ex_pkg::*;
#(
  parameter logic [7:0] IO_BASE         = 8'hA8,
  parameter logic [3:0] EXP_SLOT_MASK   = 4'b0000,
  parameter int         KEY_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  ppi_ex_if.slave     bus,
  output logic [3:0]  matrix_y,
  input  logic [7:0]  matrix_x,
  output logic        cmt_motor_off,
  output logic        cmt_write_signal,
  output logic        keyboard_caps_led_off,
  output logic        click_sound,
  output logic [3:0]  sltsl,
  output logic [15:0] sltsl_sub
);

`ifdef PPI_PORTC_BSR_EN
  localparam bit BSR_EN = 1'b1;
`else
  localparam bit BSR_EN = 1'b0;
`endif

  logic [7:0]  port_a;
  logic [7:0]  port_c;
  logic [7:0]  key_sync [KEY_SYNC_STAGES];
  logic [7:0]  sub_regs [4];
  logic [7:0]  rdata_q;
  logic        rdata_en_q;
  acc_kind_t   kind;
  logic        access;
  logic        access_q;
  logic        take;
  logic        is_wr;
  logic [7:0]  offset;
  logic        io_hit;
  logic        sub_hit;
  logic        sub_read;
  logic [1:0]  page;
  logic [1:0]  cur_slot;

  always_comb begin
    kind = ACC_NONE;
    if (!bus.iorq_n)
      kind = ACC_IO;
    else if (!bus.mreq_n)
      kind = ACC_MEM;
    is_wr    = !bus.wr_n;
    access   = (kind != ACC_NONE) && (!bus.wr_n || !bus.rd_n);
    take     = access && !access_q;
    offset   = bus.address[7:0] - IO_BASE;
    io_hit   = (kind == ACC_IO) && (offset < 8'd4);
    cur_slot = port_a[7:6];
    sub_hit  = (kind == ACC_MEM) && (bus.address == SUBSLOT_ADDR) && EXP_SLOT_MASK[cur_slot];
    sub_read = sub_hit && bus.wr_n && !bus.rd_n;
    page     = bus.address[15:14];
  end

  // Resetting to "active" means a strobe held through reset is never taken.
  always_ff @(posedge clk) begin
    if (reset)
      access_q <= 1'b1;
    else
      access_q <= access;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < KEY_SYNC_STAGES; i++)
        key_sync[i] <= 8'hFF;
    end else begin
      key_sync[0] <= matrix_x;
      for (int i = 1; i < KEY_SYNC_STAGES; i++)
        key_sync[i] <= key_sync[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_a <= 8'h00;
      port_c <= 8'h00;
    end else if (take && is_wr && io_hit) begin
      case (offset[1:0])
        PORT_A: port_a <= bus.wdata;
        PORT_B: ;
        PORT_C: port_c <= bus.wdata;
        PORT_CTRL: begin
          if (bus.wdata[7]) begin
            port_a <= 8'h00;
            port_c <= 8'h00;
          end else if (BSR_EN) begin
            port_c[bus.wdata[3:1]] <= bus.wdata[0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q    <= 8'h00;
      rdata_en_q <= 1'b0;
    end else begin
      rdata_q    <= 8'h00;
      rdata_en_q <= 1'b0;
      if (take && !is_wr && (io_hit || sub_hit)) begin
        rdata_en_q <= 1'b1;
        if (sub_hit)
          rdata_q <= ~sub_regs[cur_slot];
        else begin
          case (offset[1:0])
            PORT_A:    rdata_q <= port_a;
            PORT_B:    rdata_q <= key_sync[KEY_SYNC_STAGES-1];
            PORT_C:    rdata_q <= port_c;
            PORT_CTRL: rdata_q <= 8'hFF;
          endcase
        end
      end
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.rdata_en = rdata_en_q;

  assign matrix_y              = port_c[3:0];
  assign cmt_motor_off         = port_c[4];
  assign cmt_write_signal      = port_c[5];
  assign keyboard_caps_led_off = port_c[6];
  assign click_sound           = port_c[7];

  always_comb begin
    sltsl = sub_read ? 4'b0000 : onehot4(port_a[{page, 1'b0} +: 2]);
  end

  for (genvar p = 0; p < 4; p++) begin : g_slot
    if (EXP_SLOT_MASK[p]) begin : g_exp
      ppi_ex_subslot u_sub (
        .clk     (clk),
        .reset   (reset),
        .we      (take && is_wr && sub_hit && (cur_slot == 2'(p))),
        .wdata   (bus.wdata),
        .page    (page),
        .mute    (sub_read),
        .sub_reg (sub_regs[p]),
        .sel     (sltsl_sub[4*p +: 4])
      );
    end else begin : g_flat
      assign sub_regs[p]         = 8'h00;
      assign sltsl_sub[4*p +: 4] = 4'b0000;
    end
  end

endmodule

// File: tb/tb_ppi_ex.sv
// Directed plus randomized bench for ppi_ex with a slot 3 expansion; model tracks ports and sub registers.
module tb_ppi_ex;

  localparam logic [7:0] IO_BASE = 8'hA8;
  localparam logic [3:0] MASK    = 4'b1000;
  localparam int         STAGES  = 2;
`ifdef PPI_PORTC_BSR_EN
  localparam bit BSR = 1'b1;
`else
  localparam bit BSR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  matrix_y;
  logic [7:0]  matrix_x = 8'hFF;
  logic        cmt_motor_off;
  logic        cmt_write_signal;
  logic        keyboard_caps_led_off;
  logic        click_sound;
  logic [3:0]  sltsl;
  logic [15:0] sltsl_sub;

  ppi_ex_if bus ();

  ppi_ex #(
    .IO_BASE         (IO_BASE),
    .EXP_SLOT_MASK   (MASK),
    .KEY_SYNC_STAGES (STAGES)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .bus                   (bus),
    .matrix_y              (matrix_y),
    .matrix_x              (matrix_x),
    .cmt_motor_off         (cmt_motor_off),
    .cmt_write_signal      (cmt_write_signal),
    .keyboard_caps_led_off (keyboard_caps_led_off),
    .click_sound           (click_sound),
    .sltsl                 (sltsl),
    .sltsl_sub             (sltsl_sub)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0]  m_a;
  logic [7:0]  m_c;
  logic [7:0]  m_key;
  logic [7:0]  m_sub [4];

  logic [7:0]  rd;
  logic        en;
  logic        en2;
  logic [3:0]  sl;
  logic [15:0] sls;

  function automatic logic [7:0] portc_out();
    return {click_sound, keyboard_caps_led_off, cmt_write_signal, cmt_motor_off, matrix_y};
  endfunction

  function automatic logic [3:0] exp_sltsl(input logic [15:0] a);
    int pg = int'(a[15:14]);
    int p  = (int'(m_a) >> (2 * pg)) % 4;
    return 4'(1 << p);
  endfunction

  function automatic logic [15:0] exp_sub(input logic [15:0] a);
    int pg = int'(a[15:14]);
    logic [15:0] r = 16'h0000;
    for (int p = 0; p < 4; p++)
      if (MASK[p]) r[4 * p + ((int'(m_sub[p]) >> (2 * pg)) % 4)] = 1'b1;
    return r;
  endfunction

  // Returns {claimed, data} for a read under the current model state.
  function automatic logic [8:0] exp_read(input bit io, input logic [15:0] a);
    int off = int'(a[7:0]) - int'(IO_BASE);
    if (io) begin
      if (off == 0) return {1'b1, m_a};
      if (off == 1) return {1'b1, m_key};
      if (off == 2) return {1'b1, m_c};
      if (off == 3) return {1'b1, 8'hFF};
    end else if (a == 16'hFFFF && MASK[m_a[7:6]]) begin
      return {1'b1, ~m_sub[m_a[7:6]]};
    end
    return 9'h000;
  endfunction

  task automatic model_write(input bit io, input logic [15:0] a, input logic [7:0] d);
    int off = int'(a[7:0]) - int'(IO_BASE);
    if (io) begin
      if (off == 0) m_a = d;
      else if (off == 2) m_c = d;
      else if (off == 3) begin
        if (d[7]) begin
          m_a = 8'h00;
          m_c = 8'h00;
        end else if (BSR) begin
          m_c[d[3:1]] = d[0];
        end
      end
    end else if (a == 16'hFFFF && MASK[m_a[7:6]]) begin
      m_sub[m_a[7:6]] = d;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.iorq_n = 1'b1;
    bus.mreq_n = 1'b1;
    bus.wr_n   = 1'b1;
    bus.rd_n   = 1'b1;
  endtask

  // One access: strobe for one edge, capture during and one cycle after the return.
  task automatic applyStimulus(input bit io, input bit wr, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address = a;
    bus.wdata   = d;
    bus.iorq_n  = !io;
    bus.mreq_n  = io;
    bus.wr_n    = !wr;
    bus.rd_n    = wr;
    @(negedge clk);
    rd  = bus.rdata;
    en  = bus.rdata_en;
    sl  = sltsl;
    sls = sltsl_sub;
    bus_idle();
    @(negedge clk);
    en2 = bus.rdata_en;
  endtask

  task automatic transact(input string tag, input bit io, input bit wr, input logic [15:0] a, input logic [7:0] d);
    logic [8:0] e;
    e = wr ? 9'h000 : exp_read(io, a);
    applyStimulus(io, wr, a, d);
    if (wr) model_write(io, a, d);
    checkOutput({tag, ".en"}, 32'(en), 32'(e[8]));
    checkOutput({tag, ".data"}, 32'(rd), 32'(e[7:0]));
    checkOutput({tag, ".en_next"}, 32'(en2), 32'd0);
  endtask

  task automatic check_map(input string tag, input logic [15:0] a);
    @(negedge clk);
    bus.address = a;
    #1;
    checkOutput({tag, ".sltsl"}, 32'(sltsl), 32'(exp_sltsl(a)));
    checkOutput({tag, ".sub"}, 32'(sltsl_sub), 32'(exp_sub(a)));
    checkOutput({tag, ".portc"}, 32'(portc_out()), 32'(m_c));
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int          op;

    bus_idle();
    bus.address = 16'h0000;
    bus.wdata   = 8'h00;
    m_a = 8'h00;
    m_c = 8'h00;
    m_key = 8'hFF;
    for (int p = 0; p < 4; p++) m_sub[p] = 8'h00;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset.rdata", 32'(bus.rdata), 32'h00);
    checkOutput("reset.rdata_en", 32'(bus.rdata_en), 32'h0);
    checkOutput("reset.portc", 32'(portc_out()), 32'h00);
    check_map("reset.map", 16'h0000);

    transact("s1.wa", 1'b1, 1'b1, 16'h00A8, 8'h1B);
    for (int pg = 0; pg < 4; pg++) begin
      a = 16'(pg << 14);
      check_map("s1.page", a);
    end
    checkOutput("s1.page3", 32'(sltsl), 32'b0001);
    transact("s1.ra", 1'b1, 1'b0, 16'h00A8, 8'h00);

    @(negedge clk);
    bus.address = 16'h00AA;
    bus.wdata   = 8'hAB;
    bus.iorq_n  = 1'b0;
    bus.wr_n    = 1'b0;
    m_c = 8'hAB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("s2.held_portc", 32'(portc_out()), 32'hAB);
      bus.wdata = 8'h00;
    end
    bus_idle();
    checkOutput("s2.matrix_y", 32'(matrix_y), 32'hB);
    checkOutput("s2.lines", 32'({click_sound, keyboard_caps_led_off, cmt_write_signal, cmt_motor_off}), 32'b1010);

    @(negedge clk);
    matrix_x = 8'hA5;
    m_key = 8'hA5;
    repeat (STAGES + 1) @(negedge clk);
    transact("s3.rb", 1'b1, 1'b0, 16'h00A9, 8'h00);
    transact("s3.rctrl", 1'b1, 1'b0, 16'h00AB, 8'h00);
    transact("s3.below", 1'b1, 1'b0, 16'h00A7, 8'h00);
    transact("s3.above", 1'b1, 1'b0, 16'h00AC, 8'h00);

    transact("s4.wa", 1'b1, 1'b1, 16'h00A8, 8'hC0);
    transact("s4.wsub", 1'b0, 1'b1, 16'hFFFF, 8'hE4);
    transact("s4.rsub", 1'b0, 1'b0, 16'hFFFF, 8'h00);
    checkOutput("s4.rsub_sltsl", 32'(sl), 32'h0);
    checkOutput("s4.rsub_sub", 32'(sls), 32'h0);
    check_map("s4.p1", 16'h4000);
    checkOutput("s4.p1_bit13", 32'(sltsl_sub), 32'h2000);
    check_map("s4.p2", 16'h8000);
    checkOutput("s4.p2_bit14", 32'(sltsl_sub), 32'h4000);
    transact("s4.wa0", 1'b1, 1'b1, 16'h00A8, 8'h00);
    transact("s4.rsub_flat", 1'b0, 1'b0, 16'hFFFF, 8'h00);
    transact("s4.wsub_flat", 1'b0, 1'b1, 16'hFFFF, 8'h77);
    transact("s4.rmem", 1'b0, 1'b0, 16'h1234, 8'h00);
    transact("s4.wa3", 1'b1, 1'b1, 16'h00A8, 8'hC0);
    transact("s4.rsub_again", 1'b0, 1'b0, 16'hFFFF, 8'h00);

    transact("s5.wc", 1'b1, 1'b1, 16'h00AA, 8'h00);
    transact("s5.bsr", 1'b1, 1'b1, 16'h00AB, 8'h0F);
    checkOutput("s5.bsr_portc", 32'(portc_out()), BSR ? 32'h80 : 32'h00);
    transact("s5.mode", 1'b1, 1'b1, 16'h00AB, 8'h80);
    transact("s5.ra", 1'b1, 1'b0, 16'h00A8, 8'h00);
    transact("s5.rc", 1'b1, 1'b0, 16'h00AA, 8'h00);

    for (int it = 0; it < 150; it++) begin
      op = int'($urandom_range(0, 5));
      d  = 8'($urandom);
      a  = {8'($urandom), 8'($urandom_range(8'hA6, 8'hAD))};
      case (op)
        0: transact("rnd.iow", 1'b1, 1'b1, a, d);
        1: transact("rnd.ior", 1'b1, 1'b0, a, d);
        2: transact("rnd.memw", 1'b0, 1'b1, 16'hFFFF, d);
        3: transact("rnd.memr", 1'b0, 1'b0, ($urandom_range(0, 3) == 0) ? a : 16'hFFFF, d);
        4: begin
          @(negedge clk);
          matrix_x = d;
          m_key = d;
          repeat (STAGES + 1) @(negedge clk);
          transact("rnd.key", 1'b1, 1'b0, 16'h00A9, 8'h00);
        end
        default: check_map("rnd.map", 16'($urandom));
      endcase
    end

    transact("s6.wa", 1'b1, 1'b1, 16'h00A8, 8'hFF);
    @(negedge clk);
    bus.address = 16'h00A8;
    bus.iorq_n  = 1'b0;
    bus.rd_n    = 1'b0;
    reset       = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_a = 8'h00;
    m_c = 8'h00;
    for (int p = 0; p < 4; p++) m_sub[p] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("s6.held_en", 32'(bus.rdata_en), 32'h0);
      checkOutput("s6.held_rdata", 32'(bus.rdata), 32'h00);
    end
    checkOutput("s6.sltsl", 32'(sltsl), 32'(exp_sltsl(16'h00A8)));
    checkOutput("s6.portc", 32'(portc_out()), 32'h00);
    bus_idle();
    transact("s6.ra", 1'b1, 1'b0, 16'h00A8, 8'h00);
    check_map("s6.map", 16'hC000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
